// File: rtl/stage_commit_ctrl.sv
// Collects per-channel responses for a stage and issues one load_writeback when all requested channels are done.
// Latency: load 1 cycle after the final response (REG_OUT=1) or same cycle (REG_OUT=0); no backpressure, ch_req holds the stage.
module stage_commit_ctrl #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 0,
    parameter int REG_OUT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] ch_req_i,
    input  logic [NUM_CH-1:0] ch_resp_i,
    input  logic              flush_i,
    output logic              load_writeback_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cycles_o,
    output logic [CNT_W-1:0]  perf_stalls_o,
    output logic              timeout_err_o
);

    typedef enum logic [1:0] {IDLE, WAIT, COMMIT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [NUM_CH-1:0]  done_q, done_d;
    logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]   perf_stalls_q, perf_stalls_d;
    logic               timeout_err_q, timeout_err_d;

    logic [NUM_CH-1:0]  resp_vld;
    logic [NUM_CH-1:0]  pending;
    logic               any_req;
    logic               all_done;
    logic               in_commit;
    logic               stall_int;
    logic               load_int;

    // A response on a channel with no request is dropped here.
    assign resp_vld  = ch_resp_i & ch_req_i;
    assign pending   = ch_req_i & ~done_q & ~ch_resp_i;
    assign any_req   = |ch_req_i;
    assign all_done  = any_req && (pending == '0);
    assign in_commit = (state_q == COMMIT);
    assign stall_int = any_req && !all_done && !in_commit && !flush_i;

    always_comb begin
        if (REG_OUT != 0) begin
            load_int = in_commit && !flush_i;
        end else begin
            load_int = all_done && !flush_i && !in_commit;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign load_writeback_o = rst_ni && load_int;
    assign stall_o          = rst_ni && stall_int;
    assign stall_cycles_o   = stall_cycles_q;
    assign perf_stalls_o    = perf_stalls_q;
    assign timeout_err_o    = timeout_err_q;

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        if (flush_i) begin
            state_d = IDLE;
            done_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_d = '0;
                    if (all_done) begin
                        state_d = (REG_OUT != 0) ? COMMIT : IDLE;
                    end else if (any_req) begin
                        state_d = WAIT;
                        done_d  = resp_vld;
                    end
                end
                WAIT: begin
                    done_d = done_q | resp_vld;
                    if (all_done) begin
                        state_d = (REG_OUT != 0) ? COMMIT : IDLE;
                        done_d  = '0;
                    end
                end
                COMMIT: begin
                    state_d = IDLE;
                    done_d  = '0;
                end
                default: begin
                    state_d = IDLE;
                    done_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        perf_stalls_d  = perf_stalls_q;
        timeout_err_d  = timeout_err_q;
        if (flush_i || all_done) begin
            stall_cycles_d = '0;
        end else if (stall_int && stall_cycles_q != CNT_MAX) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (stall_int && perf_stalls_q != CNT_MAX) begin
            perf_stalls_d = perf_stalls_q + CNT_W'(1);
        end
        if (TIMEOUT != 0 && stall_int && stall_cycles_q == TO_M1) begin
            timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            done_q         <= '0;
            stall_cycles_q <= '0;
            perf_stalls_q  <= '0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            done_q         <= done_d;
            stall_cycles_q <= stall_cycles_d;
            perf_stalls_q  <= perf_stalls_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

endmodule
